tristate_bus_arbiter: RTL and testbench
=======================================

Name: tristate_bus_arbiter

Overview:
Round-robin arbiter that shares one tri-state bus among NUM_REQ requesters. Each requester owns a tri-state driver of the x/en form, where y = en ? x : 'z. The block produces the one-hot driver enables. Enables are never overlapped, and a mandatory turnaround gap separates owners, so the shared y net is never contended.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
MAX_HOLD, 8, max consecutive grant cycles before preemption (>=1; used only with ARB_PREEMPT_EN)
TURNAROUND, 1, all-enables-off cycles between owners (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester bus request, level
done  input  NUM_REQ  per-requester release, sampled only for current owner
gnt  output  NUM_REQ  one-hot grant; drives the tri-state en of each requester; registered
owner  output  $clog2(NUM_REQ)  index of current owner; valid when owner_vld=1
owner_vld  output  1  high while any gnt bit is high
preempt  output  1  1-cycle pulse when a grant is revoked by the hold limit

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values:
  - gnt=0, owner=0, owner_vld=0, preempt=0
  - state=IDLE, hold_cnt=0, turn_cnt=0
  - last_owner=NUM_REQ-1, so req[0] has top priority after reset
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req!=0 at edge N, pick the first set bit scanning from (last_owner+1) mod NUM_REQ upward with wrap.
  - gnt/owner/owner_vld take the result at edge N, i.e. visible in cycle N+1. Grant latency is 1 cycle.
  - Go to GRANT with hold_cnt=0.
  - If req==0, stay in IDLE.
- GRANT:
  - gnt is constant and one-hot; hold_cnt increments each cycle and saturates.
  - Release condition: done[owner]=1, or req[owner]=0, or a preemption (optional feature).
  - On release: gnt=0, owner_vld=0 from the next cycle; last_owner=owner; go to TURN with turn_cnt=0.
  - done/req on non-owner lines are ignored for release.
- TURN:
  - gnt=0 for exactly TURNAROUND cycles.
  - In the last TURN cycle, arbitrate exactly as IDLE. If req!=0, go directly to GRANT, giving a gap of exactly TURNAROUND cycles. Otherwise go to IDLE.
- owner holds its last value when owner_vld=0.
- Invariants every cycle:
  - $onehot0(gnt)
  - owner_vld == |gnt
  - gnt[i] -> owner==i
- Simultaneous events:
  - done and req drop in the same cycle: a single release.
  - A new req arriving during TURN is eligible at the end of TURN.
  - The old owner re-requesting is lowest priority unless it is the only requester.
- Reset mid-operation: rst overrides everything. gnt drops at that edge, state returns to IDLE and last_owner to NUM_REQ-1. No preempt pulse is generated by reset.
- Boundaries:
  - Wrap from requester NUM_REQ-1 to 0 is handled in the round-robin scan.
  - req all-ones with immediate done gives strict rotation 0,1,…,NUM_REQ-1,0.

Optional Feature:
ARB_PREEMPT_EN
- Defined:
  - In GRANT, when hold_cnt==MAX_HOLD-1 and no done/req-drop occurs, release at that edge.
  - gnt is therefore high for exactly MAX_HOLD cycles.
  - preempt=1 for the single following cycle (first TURN cycle), then 0.
  - A natural release in the same cycle takes precedence: no preempt pulse.
- Undefined:
  - No hold limit; the owner keeps the bus until done or req drop.
  - preempt is tied to 0.
  - The MAX_HOLD parameter is unused.

Test Plan:
All scenarios use NUM_REQ=4, TURNAROUND=1, MAX_HOLD=8.
1. Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, owner_vld=0, preempt=0 throughout. First cycle after rst falls samples req; the next cycle shows gnt=4'b0001, owner=0.
2. Single requester: req=4'b0100 sampled at edge N -> gnt=4'b0100, owner=2 in cycle N+1. done[2]=1 at edge M -> gnt=0 for 1 cycle, then IDLE. A concurrent done[1] is ignored.
3. Rotation: req=4'b1111 held, each owner pulses done in its first grant cycle -> gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001. Gap is exactly 1 cycle.
4. Preemption (ARB_PREEMPT_EN): req=4'b0011 held, no done -> gnt=0001 for exactly 8 cycles, preempt=1 for 1 cycle with gnt=0, then gnt=0010. Without the macro, gnt=0001 persists for >=50 cycles and preempt stays 0.
5. Reset mid-grant: gnt=4'b1000, rst=1 for 1 cycle with req=4'b1010 -> gnt=0 at the reset edge. Next grant is 0010, since priority restarts at 0.
6. Req drop: owner 1 deasserts req[1] without done while req=4'b0001 -> gnt=0 next cycle, 1 turn cycle, then gnt=0001.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter
// Round-robin owner selection for a shared tri-state bus. Each requester
// drives the bus through its own x/en buffer; this block produces the
// one-hot enables (gnt), keeps them non-overlapping and inserts TURNAROUND
// all-off cycles between consecutive owners so the shared net never sees
// two drivers.
//
// Optional build macro: ARB_PREEMPT_EN
//   defined   - an owner is revoked after MAX_HOLD consecutive grant cycles
//               and preempt pulses for one cycle afterwards
//   undefined - owners keep the bus until done or request drop; preempt is
//               held at 0 and MAX_HOLD has no effect
module tristate_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MAX_HOLD   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       owner_vld,
  output logic                       preempt
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURNAROUND + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [OW-1:0]     owner_nxt;
  logic              owner_vld_nxt;
  logic              preempt_nxt;
  logic [HW-1:0]     hold_cnt;
  logic [HW-1:0]     hold_cnt_nxt;
  logic [TW-1:0]     turn_cnt;
  logic [TW-1:0]     turn_cnt_nxt;
  logic [OW-1:0]     last_owner;
  logic [OW-1:0]     last_owner_nxt;

  logic              pick_vld;
  logic [OW-1:0]     pick_idx;
  logic              natural_rel;
  logic              hold_limit;
  int                scan_idx;
  logic [OW-1:0]     scan_sel;

  // Round-robin scan: first active request after last_owner, wrapping, so
  // the previous owner is examined last and only wins when alone.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = 0;
    scan_sel = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan_idx = int'(last_owner) + i;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end
      scan_sel = scan_idx[OW-1:0];
      if (!pick_vld && req[scan_sel]) begin
        pick_vld = 1'b1;
        pick_idx = scan_sel;
      end
    end
  end

  // Next-state and registered-output values for the IDLE/GRANT/TURN sequencer.
  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    owner_nxt      = owner;
    owner_vld_nxt  = owner_vld;
    preempt_nxt    = 1'b0;
    hold_cnt_nxt   = hold_cnt;
    turn_cnt_nxt   = turn_cnt;
    last_owner_nxt = last_owner;

    // Only the current owner's done/req lines can end a grant.
    natural_rel = done[owner] | ~req[owner];
    hold_limit  = 1'b0;
`ifdef ARB_PREEMPT_EN
    // A natural release on the same edge wins, so no preempt pulse then.
    hold_limit = (hold_cnt == HW'(MAX_HOLD - 1)) && !natural_rel;
`endif

    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt     = GRANT;
          gnt_nxt       = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          owner_nxt     = pick_idx;
          owner_vld_nxt = 1'b1;
          hold_cnt_nxt  = '0;
        end
      end

      GRANT: begin
        if (natural_rel || hold_limit) begin
          state_nxt      = TURN;
          gnt_nxt        = '0;
          owner_vld_nxt  = 1'b0;
          last_owner_nxt = owner;
          turn_cnt_nxt   = '0;
          preempt_nxt    = hold_limit;
        end else if (hold_cnt != {HW{1'b1}}) begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end

      TURN: begin
        if (turn_cnt == TW'(TURNAROUND - 1)) begin
          if (pick_vld) begin
            state_nxt     = GRANT;
            gnt_nxt       = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            owner_nxt     = pick_idx;
            owner_vld_nxt = 1'b1;
            hold_cnt_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          turn_cnt_nxt = turn_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt     = IDLE;
        gnt_nxt       = '0;
        owner_vld_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset restores req[0] as top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      owner      <= '0;
      owner_vld  <= 1'b0;
      preempt    <= 1'b0;
      hold_cnt   <= '0;
      turn_cnt   <= '0;
      last_owner <= OW'(NUM_REQ - 1);
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      owner      <= owner_nxt;
      owner_vld  <= owner_vld_nxt;
      preempt    <= preempt_nxt;
      hold_cnt   <= hold_cnt_nxt;
      turn_cnt   <= turn_cnt_nxt;
      last_owner <= last_owner_nxt;
    end
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb_tristate_bus_arbiter
// Directed scoreboard bench: each step drives inputs, queues the outputs
// expected after the next rising edge, then pops and checks them.
module tb_tristate_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       owner_vld;
  logic       preempt;

  int compared;
  int mismatched;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       vld;
    logic       pre;
  } exp_t;

  exp_t exp_q[$];

  tristate_bus_arbiter #(
    .NUM_REQ   (4),
    .MAX_HOLD  (8),
    .TURNAROUND(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .owner    (owner),
    .owner_vld(owner_vld),
    .preempt  (preempt)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      mismatched++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = exp_q.pop_front();
    compared++;
    assert (gnt === e.gnt) else begin
      mismatched++;
      $error("[TB] FAIL %s gnt observed=%b expected=%b", e.tag, gnt, e.gnt);
    end
    compared++;
    assert (owner === e.owner) else begin
      mismatched++;
      $error("[TB] FAIL %s owner observed=%0d expected=%0d", e.tag, owner, e.owner);
    end
    compared++;
    assert (owner_vld === e.vld) else begin
      mismatched++;
      $error("[TB] FAIL %s owner_vld observed=%b expected=%b", e.tag, owner_vld, e.vld);
    end
    compared++;
    assert (preempt === e.pre) else begin
      mismatched++;
      $error("[TB] FAIL %s preempt observed=%b expected=%b", e.tag, preempt, e.pre);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, check.
  task automatic applyStimulus(input string tag, input logic r, input logic [3:0] rq,
                               input logic [3:0] dn, input logic [3:0] eg,
                               input logic [1:0] eo, input logic ev, input logic ep);
    exp_t e;
    rst  = r;
    req  = rq;
    done = dn;
    e.tag   = tag;
    e.gnt   = eg;
    e.owner = eo;
    e.vld   = ev;
    e.pre   = ep;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst  = 1'b1;
    req  = 4'b0000;
    done = 4'b0000;

    // Reset held with all requests active
    applyStimulus("reset0", 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus("reset1", 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus("first_grant", 1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);

    // Strict rotation with immediate done, including wrap 3 -> 0
    applyStimulus("rot_rel0", 1'b0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus("rot_g1",   1'b0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus("rot_rel1", 1'b0, 4'b1111, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0);
    applyStimulus("rot_g2",   1'b0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus("rot_rel2", 1'b0, 4'b1111, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0);
    applyStimulus("rot_g3",   1'b0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus("rot_rel3", 1'b0, 4'b1111, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0);
    applyStimulus("rot_wrap", 1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus("rot_end",  1'b0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus("to_idle",  1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus("idle",     1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester; done on a non-owner line is ignored
    applyStimulus("single_g2",  1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus("foreign_dn", 1'b0, 4'b0100, 4'b0010, 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus("single_rel", 1'b0, 4'b0100, 4'b0110, 4'b0000, 2'd2, 1'b0, 1'b0);
    applyStimulus("single_trn", 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    applyStimulus("single_idl", 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

    // Hold limit: last owner 2, so req 0011 grants 0 first
    applyStimulus("hold_g0", 1'b0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef ARB_PREEMPT_EN
    for (int k = 0; k < 7; k++) begin
      applyStimulus("hold_keep", 1'b0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    applyStimulus("preempt_pulse", 1'b0, 4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
    applyStimulus("preempt_next",  1'b0, 4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus("preempt_done",  1'b0, 4'b0011, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0);
`else
    for (int k = 0; k < 55; k++) begin
      applyStimulus("hold_keep", 1'b0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    applyStimulus("hold_done", 1'b0, 4'b0011, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

    // Reset in the middle of a grant to requester 3
    applyStimulus("g3",        1'b0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus("mid_reset", 1'b1, 4'b1010, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus("post_rst",  1'b0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);

    // Owner drops its request without done
    applyStimulus("req_drop",  1'b0, 4'b0001, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
    applyStimulus("drop_next", 1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);

    // Old owner wins again when it is the only requester
    applyStimulus("own_rel",   1'b0, 4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus("own_again", 1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);

    // done and req drop together give a single release
    applyStimulus("both_rel",  1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus("both_idle", 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Request arriving in TURN is served at the end of TURN
    applyStimulus("turn_g1",   1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus("turn_rel",  1'b0, 4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0);
    applyStimulus("turn_new",  1'b0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
